// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the CPU's MEM-stage data port. It accepts one load
// or store at a time over a valid/ready request handshake. It services the
// access from an internal word array after a fixed latency. It then returns
// load data, or a store acknowledge, over a valid/ready response handshake.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the array (power of two, >= 2)
//   LATENCY      edges from request acceptance to rsp_valid rising (>= 1)
//   BASE_ADDR    byte address of word 0 (word aligned)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request this cycle
//   req_write  1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_bmask  store byte-lane enables (bit i -> bits 8i+7:8i)
//   rsp_valid  response present
//   rsp_ready  CPU accepts the response
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    misaligned or out-of-range access
//   busy       high whenever the responder is not idle
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_bmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Request captured at acceptance; decoded and committed at the end of WAIT.
  logic             cap_write;
  logic [31:0]      cap_addr;
  logic [31:0]      cap_wdata;
  logic [3:0]       cap_bmask;

  logic [31:0]      mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Address decode on the captured request
  // ---------------------------------------------------------------------------
  logic [31:0]      offset;
  logic [31:0]      word_off;
  logic [IDX_W-1:0] idx;
  logic             addr_err;
  logic             commit;
  logic             mem_we;

  // NOTE: every signal driven here gets a value on every path, so no latch is
  // inferred.
  always_comb begin
    offset   = cap_addr - BASE_ADDR;   // unsigned wrap; the range test catches it
    word_off = offset >> 2;
    idx      = offset[IDX_W+1:2];
    addr_err = (cap_addr[1:0] != 2'b00)
            || (cap_addr < BASE_ADDR)
            || (word_off >= 32'(DEPTH_WORDS));
    commit   = (state == S_WAIT) && (cnt == '0);
    mem_we   = commit && cap_write && !addr_err;
  end

  // ---------------------------------------------------------------------------
  // Word array. Only enabled byte lanes are written at the commit edge.
  // An async reset forces state out of WAIT, so a store that has not reached
  // its commit edge never lands.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; its contents survive a reset, and leaving it
  // out of the reset lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cap_bmask[b]) mem[idx][8*b +: 8] <= cap_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_bmask <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_bmask <= req_bmask;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= addr_err;
            rsp_rdata <= (!cap_write && !addr_err) ? mem[idx] : '0;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_RESP: begin
          // Data and error stay frozen until the CPU takes the response.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Two responders share one clock and one reset:
//   u0: LATENCY=2, BASE_ADDR=0x0000
//   u1: LATENCY=1, BASE_ADDR=0x1000
// Stimulus pushes the expected response into a per-instance queue. A monitor
// pops the queue and compares on every response handshake, and also checks the
// acceptance-to-rsp_valid latency.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          id;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_bmask [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  exp_t q0[$];
  exp_t q1[$];

  int tests;
  int fails;
  int cyc;
  int next_id;
  int acc_edge  [2];
  int rise_lat  [2];
  logic prev_valid [2];

  data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2), .BASE_ADDR(32'h0000)) u0 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_bmask(req_bmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(1), .BASE_ADDR(32'h1000)) u1 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_bmask(req_bmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: latency tracking and scoreboard comparison at the handshake
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (req_valid[i] === 1'b1 && req_ready[i] === 1'b1) acc_edge[i] = cyc + 1;
      if (rsp_valid[i] === 1'b1 && prev_valid[i] !== 1'b1) rise_lat[i] = cyc - acc_edge[i];
      prev_valid[i] = rsp_valid[i];
      if (rsp_valid[i] === 1'b1 && rsp_ready[i] === 1'b1) begin
        if (qsize(i) == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp u%0d: got rdata %h err %b, required no response",
                   i, rsp_rdata[i], rsp_err[i]);
        end else begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("u%0d.rsp%0d.rdata", i, e.id), rsp_rdata[i], e.rdata);
          check($sformatf("u%0d.rsp%0d.err", i, e.id), 32'(rsp_err[i]), 32'(e.err));
          check($sformatf("u%0d.rsp%0d.latency", i, e.id), 32'(rise_lat[i]), 32'(e.lat));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_exp(input int sel, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.lat   = (sel == 0) ? 2 : 1;
    e.id    = next_id++;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // Present a request and hold it until accepted; returns 1 ns after the
  // acceptance edge.
  task automatic issue(input int sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] bmask);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    req_valid[sel] = 1'b1;
    req_write[sel] = wr;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    req_bmask[sel] = bmask;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[sel] === 1'b1) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL u%0d.accept_timeout: got req_ready=0 for 50 cycles, required 1", sel);
    end
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
  endtask

  task automatic wait_drain(input int sel);
    for (int k = 0; k < 60; k++) begin
      if (qsize(sel) == 0) return;
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL u%0d.rsp_timeout: got %0d responses outstanding, required 0", sel, qsize(sel));
  endtask

  task automatic xact(input int sel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] bmask,
                      input logic [31:0] exp_rdata, input logic exp_err);
    push_exp(sel, exp_rdata, exp_err);
    issue(sel, wr, addr, wdata, bmask);
    wait_drain(sel);
  endtask

  // Store that is killed by a reset pulse while still in WAIT.
  task automatic reset_in_wait(input int sel, input logic [31:0] addr);
    issue(sel, 1'b1, addr, 32'h0000_0099, 4'hF);
    check($sformatf("u%0d.busy_in_wait", sel), 32'(busy[sel]), 32'd1);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check($sformatf("u%0d.post_rst.req_ready", sel), 32'(req_ready[sel]), 32'd1);
    check($sformatf("u%0d.post_rst.busy", sel), 32'(busy[sel]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("u%0d.post_rst.no_rsp%0d", sel, k), 32'(rsp_valid[sel]), 32'd0);
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    tests   = 0;
    fails   = 0;
    cyc     = 0;
    next_id = 0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_bmask[i] = '0;
      rsp_ready[i] = 1'b1;
      acc_edge[i]  = 0;
      rise_lat[i]  = 0;
      prev_valid[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset / idle state
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d.rst.req_ready", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("u%0d.rst.rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      check($sformatf("u%0d.rst.busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("u%0d.rst.rsp_rdata", i), rsp_rdata[i], 32'd0);
    end

    // Full-word store and load (u0, latency 2)
    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte-lane stores
    xact(0, 1'b1, 32'h14, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    xact(0, 1'b1, 32'h14, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h14, 32'h0, 4'h0, 32'h1122_33AA, 1'b0);
    xact(0, 1'b1, 32'h14, 32'hCCDD_EEFF, 4'b1010, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h14, 32'h0, 4'h0, 32'hCC22_EEAA, 1'b0);
    xact(0, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);   // empty mask: no-op
    xact(0, 1'b0, 32'h14, 32'h0, 4'h0, 32'hCC22_EEAA, 1'b0);

    // Errors leave the array untouched
    xact(0, 1'b0, 32'h12,  32'h0, 4'h0, 32'h0, 1'b1);              // misaligned load
    xact(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1);              // one past the end
    xact(0, 1'b1, 32'h16,  32'h0, 4'hF, 32'h0, 1'b1);              // misaligned store
    xact(0, 1'b1, 32'h114, 32'h0, 4'hF, 32'h0, 1'b1);              // out-of-range store
    xact(0, 1'b0, 32'h14,  32'h0, 4'h0, 32'hCC22_EEAA, 1'b0);
    xact(0, 1'b1, 32'hFC, 32'h5A5A_0001, 4'hF, 32'h0, 1'b0);       // last word
    xact(0, 1'b0, 32'hFC, 32'h0, 4'h0, 32'h5A5A_0001, 1'b0);

    // Backpressure in RESP with an ignored request pulse
    xact(0, 1'b1, 32'h18, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
    rsp_ready[0] = 1'b0;
    push_exp(0, 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h18;
    req_wdata[0] = 32'h1234_5678;
    req_bmask[0] = 4'hF;
    for (int k = 0; k < 50 && rsp_valid[0] !== 1'b1; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d.rsp_valid", k), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp%0d.rsp_rdata", k), rsp_rdata[0], 32'hDEAD_BEEF);
      check($sformatf("bp%0d.req_ready", k), 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
      req_valid[0] = (k == 1);
      rsp_ready[0] = (k == 4);
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("bp.release.req_ready", 32'(req_ready[0]), 32'd1);
    check("bp.release.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    xact(0, 1'b0, 32'h18, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);

    // Reset during WAIT of a store (u0)
    xact(0, 1'b1, 32'h20, 32'h0000_0005, 4'hF, 32'h0, 1'b0);
    reset_in_wait(0, 32'h20);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0000_0005, 1'b0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);     // committed store survives

    // u1: latency 1, base 0x1000
    xact(1, 1'b1, 32'h1010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h1010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    xact(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, 32'h0, 1'b1);             // below base
    xact(1, 1'b0, 32'h1100, 32'h0, 4'h0, 32'h0, 1'b1);             // one past the end
    xact(1, 1'b1, 32'h10FC, 32'h0000_C0DE, 4'b0011, 32'h0, 1'b0);
    xact(1, 1'b1, 32'h10FC, 32'hABCD_0000, 4'b1100, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h10FC, 32'h0, 4'h0, 32'hABCD_C0DE, 1'b0);
    xact(1, 1'b1, 32'h1020, 32'h0000_0005, 4'hF, 32'h0, 1'b0);
    reset_in_wait(1, 32'h1020);
    xact(1, 1'b0, 32'h1020, 32'h0, 4'h0, 32'h0000_0005, 1'b0);

    repeat (3) @(negedge clk);
    check("u0.queue_empty", 32'(q0.size()), 32'd0);
    check("u1.queue_empty", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
